// File: rtl/proc_mem_pipe.sv
// proc_mem_pipe: unified instruction/data word memory with two independent
// val/rdy ports and a fixed-latency, stallable response pipeline per port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imemreq_*  / imemresp_*  read-only instruction port (addr in, data out)
//   dmemreq_*  / dmemresp_*  data port: type (0 rd / 1 wr), addr, wdata,
//                            byte strobes in; type echo and rdata out
//
// Word index is addr[$clog2(NWORDS)+1:2]; the byte offset and upper address
// bits are ignored, so addresses wrap modulo NWORDS. The array itself is not
// reset; only pipeline valid/data state is.

// proc_mem_pipe_stage: LAT-deep response shift pipeline. The whole pipe
// freezes while the last stage holds a response the consumer has not taken.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   in_val        a request is accepted this cycle
//   in_data       payload captured into stage 0
//   resp_rdy      consumer ready for the last stage
//   adv_c         pipeline advances at the next edge (combinational)
//   out_val       last stage valid (registered)
//   out_data      last stage payload (registered)
module proc_mem_pipe_stage #(
    parameter int unsigned W   = 33,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_val,
    input  logic [W-1:0] in_data,
    input  logic         resp_rdy,
    output logic         adv_c,
    output logic         out_val,
    output logic [W-1:0] out_data
);

    logic         val_q  [LAT];
    logic [W-1:0] data_q [LAT];

    // Whole-port stall: bubbles are not squeezed out.
    assign adv_c = !(val_q[LAT-1] && !resp_rdy);

    // Shift register of {valid, payload}; payload cleared in reset so the
    // response data reads as zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                val_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else if (adv_c) begin
            val_q[0]  <= in_val;
            data_q[0] <= in_data;
            for (int unsigned i = 1; i < LAT; i++) begin
                val_q[i]  <= val_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_val  = val_q[LAT-1];
    assign out_data = data_q[LAT-1];

endmodule

module proc_mem_pipe #(
    parameter int unsigned NWORDS = 64,
    parameter int unsigned LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    input  logic        imemresp_rdy,
    output logic [31:0] imemresp_data,

    input  logic        dmemreq_val,
    output logic        dmemreq_rdy,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    input  logic [3:0]  dmemreq_wstrb,
    output logic        dmemresp_val,
    input  logic        dmemresp_rdy,
    output logic        dmemresp_type,
    output logic [31:0] dmemresp_rdata
);

    localparam int unsigned AW = $clog2(NWORDS);
    localparam int unsigned DW = 32;

    logic [DW-1:0] mem [NWORDS];

    logic          run_q;
    logic [AW-1:0] iidx_c;
    logic [AW-1:0] didx_c;
    logic          imem_adv_c;
    logic          dmem_adv_c;
    logic          imem_acc_c;
    logic          dmem_acc_c;
    logic [DW-1:0] imem_in_c;
    logic [DW:0]   dmem_in_c;
    logic [DW:0]   dmem_out;
    logic          unused_c;

    // Holds ready low in reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign iidx_c = imemreq_addr[AW+1:2];
    assign didx_c = dmemreq_addr[AW+1:2];

    assign imemreq_rdy = run_q && imem_adv_c;
    assign dmemreq_rdy = run_q && dmem_adv_c;
    assign imem_acc_c  = imemreq_val && imemreq_rdy;
    assign dmem_acc_c  = dmemreq_val && dmemreq_rdy;

    // Array read in the accept cycle; a same-cycle write lands at the edge,
    // so a colliding imem read sees the old word.
    assign imem_in_c = imem_acc_c ? mem[iidx_c] : '0;
    assign dmem_in_c = !dmem_acc_c  ? '0 :
                       dmemreq_type ? {1'b1, {DW{1'b0}}} :
                                      {1'b0, mem[didx_c]};

    // Byte-strobed write committed at the accept edge.
    always_ff @(posedge clk) begin
        if (dmem_acc_c && dmemreq_type) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (dmemreq_wstrb[b]) begin
                    mem[didx_c][8*b +: 8] <= dmemreq_wdata[8*b +: 8];
                end
            end
        end
    end

    proc_mem_pipe_stage #(.W(DW), .LAT(LAT)) u_ipipe (
        .clk      (clk),
        .rst      (rst),
        .in_val   (imem_acc_c),
        .in_data  (imem_in_c),
        .resp_rdy (imemresp_rdy),
        .adv_c    (imem_adv_c),
        .out_val  (imemresp_val),
        .out_data (imemresp_data)
    );

    proc_mem_pipe_stage #(.W(DW + 1), .LAT(LAT)) u_dpipe (
        .clk      (clk),
        .rst      (rst),
        .in_val   (dmem_acc_c),
        .in_data  (dmem_in_c),
        .resp_rdy (dmemresp_rdy),
        .adv_c    (dmem_adv_c),
        .out_val  (dmemresp_val),
        .out_data (dmem_out)
    );

    assign {dmemresp_type, dmemresp_rdata} = dmem_out;

    // Address bits outside the word index are intentionally ignored.
    assign unused_c = ^{imemreq_addr[31:AW+2], imemreq_addr[1:0],
                        dmemreq_addr[31:AW+2], dmemreq_addr[1:0]};

endmodule

// File: tb/tb_proc_mem_pipe.sv
// Bench for proc_mem_pipe: three instances (LAT = 1, 2, 3), a word-array and
// response-queue reference model, directed vector table, hand-written
// backpressure / mid-flight reset sequences, and randomized traffic.
module tb_proc_mem_pipe;

    localparam int NI = 3;
    localparam int NW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst            [NI];
    logic        imemreq_val    [NI];
    logic        imemreq_rdy    [NI];
    logic [31:0] imemreq_addr   [NI];
    logic        imemresp_val   [NI];
    logic        imemresp_rdy   [NI];
    logic [31:0] imemresp_data  [NI];
    logic        dmemreq_val    [NI];
    logic        dmemreq_rdy    [NI];
    logic        dmemreq_type   [NI];
    logic [31:0] dmemreq_addr   [NI];
    logic [31:0] dmemreq_wdata  [NI];
    logic [3:0]  dmemreq_wstrb  [NI];
    logic        dmemresp_val   [NI];
    logic        dmemresp_rdy   [NI];
    logic        dmemresp_type  [NI];
    logic [31:0] dmemresp_rdata [NI];

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        proc_mem_pipe #(.NWORDS(NW), .LAT(g + 1)) u_dut (
            .clk            (clk),
            .rst            (rst[g]),
            .imemreq_val    (imemreq_val[g]),
            .imemreq_rdy    (imemreq_rdy[g]),
            .imemreq_addr   (imemreq_addr[g]),
            .imemresp_val   (imemresp_val[g]),
            .imemresp_rdy   (imemresp_rdy[g]),
            .imemresp_data  (imemresp_data[g]),
            .dmemreq_val    (dmemreq_val[g]),
            .dmemreq_rdy    (dmemreq_rdy[g]),
            .dmemreq_type   (dmemreq_type[g]),
            .dmemreq_addr   (dmemreq_addr[g]),
            .dmemreq_wdata  (dmemreq_wdata[g]),
            .dmemreq_wstrb  (dmemreq_wstrb[g]),
            .dmemresp_val   (dmemresp_val[g]),
            .dmemresp_rdy   (dmemresp_rdy[g]),
            .dmemresp_type  (dmemresp_type[g]),
            .dmemresp_rdata (dmemresp_rdata[g])
        );
    end

    // Values to apply at the next negedge.
    logic        d_rst   [NI];
    logic        d_ival  [NI];
    logic [31:0] d_iaddr [NI];
    logic        d_irr   [NI];
    logic        d_dval  [NI];
    logic        d_dtyp  [NI];
    logic [31:0] d_daddr [NI];
    logic [31:0] d_wdata [NI];
    logic [3:0]  d_wstrb [NI];
    logic        d_drr   [NI];

    // Reference model: memory contents, and per port an ordered queue of
    // expected responses tagged with their stall-free due time.
    typedef struct {
        logic        typ;
        logic [31:0] data;
        logic        known;
        int          eff;
    } exp_t;

    logic [31:0] mm  [NI][NW];
    logic        mk  [NI][NW];
    exp_t        q   [2*NI][$];
    logic [32:0] got [2*NI][$];
    int          st  [2*NI];
    int          age [NI];
    logic        acc_i [NI];
    logic        acc_d [NI];
    int          cyc = 0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic port_chk(input int g, input int p, input logic v, input logic rr,
                            input logic typ, input logic [31:0] data, input logic rdy);
        int    k;
        logic  exp_v;
        string nm;
        k  = 2*g + p;
        nm = $sformatf("%s%0d", (p == 1) ? "dmem" : "imem", g);
        // Head is due once LAT non-stalled cycles have elapsed since accept.
        exp_v = (q[k].size() > 0) && (q[k][0].eff + g + 1 <= cyc - st[k]);
        chk({nm, "_resp_val"}, 64'(v), 64'(exp_v));
        if (age[g] >= 2)
            chk({nm, "_req_rdy"}, 64'(rdy), 64'(!(exp_v && !rr)));
        if (v && exp_v) begin
            if (p == 1) chk({nm, "_resp_type"}, 64'(typ), 64'(q[k][0].typ));
            if (q[k][0].known) chk({nm, "_resp_data"}, 64'(data), 64'(q[k][0].data));
            if (rr) begin
                void'(q[k].pop_front());
                got[k].push_back({typ, data});
            end
        end
        if (exp_v && !rr) st[k]++;
    endtask

    task automatic tick();
        exp_t        e;
        int          w;
        logic [31:0] t;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            rst[g]           = d_rst[g];
            imemreq_val[g]   = d_ival[g];
            imemreq_addr[g]  = d_iaddr[g];
            imemresp_rdy[g]  = d_irr[g];
            dmemreq_val[g]   = d_dval[g];
            dmemreq_type[g]  = d_dtyp[g];
            dmemreq_addr[g]  = d_daddr[g];
            dmemreq_wdata[g] = d_wdata[g];
            dmemreq_wstrb[g] = d_wstrb[g];
            dmemresp_rdy[g]  = d_drr[g];
        end
        #1;
        cyc++;
        for (int g = 0; g < NI; g++) begin
            acc_i[g] = 1'b0;
            acc_d[g] = 1'b0;
            if (!d_rst[g]) begin
                age[g] = 0;
                q[2*g].delete();
                q[2*g+1].delete();
                chk($sformatf("rst_imemreq_rdy%0d", g),    64'(imemreq_rdy[g]),    64'(0));
                chk($sformatf("rst_dmemreq_rdy%0d", g),    64'(dmemreq_rdy[g]),    64'(0));
                chk($sformatf("rst_imemresp_val%0d", g),   64'(imemresp_val[g]),   64'(0));
                chk($sformatf("rst_dmemresp_val%0d", g),   64'(dmemresp_val[g]),   64'(0));
                chk($sformatf("rst_imemresp_data%0d", g),  64'(imemresp_data[g]),  64'(0));
                chk($sformatf("rst_dmemresp_rdata%0d", g), 64'(dmemresp_rdata[g]), 64'(0));
                chk($sformatf("rst_dmemresp_type%0d", g),  64'(dmemresp_type[g]),  64'(0));
            end else begin
                age[g]++;
                port_chk(g, 0, imemresp_val[g], d_irr[g], 1'b0, imemresp_data[g], imemreq_rdy[g]);
                port_chk(g, 1, dmemresp_val[g], d_drr[g], dmemresp_type[g], dmemresp_rdata[g],
                         dmemreq_rdy[g]);
                // imem sees the array before this cycle's dmem write.
                if (d_ival[g] && imemreq_rdy[g]) begin
                    w       = int'((d_iaddr[g] >> 2) % NW);
                    e.typ   = 1'b0;
                    e.data  = mm[g][w];
                    e.known = mk[g][w];
                    e.eff   = cyc - st[2*g];
                    q[2*g].push_back(e);
                    acc_i[g] = 1'b1;
                end
                if (d_dval[g] && dmemreq_rdy[g]) begin
                    w       = int'((d_daddr[g] >> 2) % NW);
                    e.eff   = cyc - st[2*g+1];
                    e.typ   = d_dtyp[g];
                    if (d_dtyp[g]) begin
                        e.data  = 32'h0;
                        e.known = 1'b1;
                        t = mm[g][w];
                        for (int b = 0; b < 4; b++)
                            if (d_wstrb[g][b]) t[8*b +: 8] = d_wdata[g][8*b +: 8];
                        mm[g][w] = t;
                        mk[g][w] = mk[g][w] || (d_wstrb[g] == 4'hF);
                    end else begin
                        e.data  = mm[g][w];
                        e.known = mk[g][w];
                    end
                    q[2*g+1].push_back(e);
                    acc_d[g] = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        int          g;
        logic        ival;
        logic [31:0] iaddr;
        logic        dval;
        logic        dtyp;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_i;
        logic [32:0] exp_d;
    } vec_t;

    vec_t vt [$];

    task automatic addv(input int g, input logic ival, input logic [31:0] iaddr,
                        input logic dval, input logic dtyp, input logic [31:0] daddr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_i, input logic [32:0] exp_d);
        vec_t v;
        v.g = g; v.ival = ival; v.iaddr = iaddr; v.dval = dval; v.dtyp = dtyp;
        v.daddr = daddr; v.wdata = wdata; v.wstrb = wstrb; v.exp_i = exp_i; v.exp_d = exp_d;
        vt.push_back(v);
    endtask

    // Issue one vector (imem and/or dmem in the same cycle), drain, compare.
    task automatic run_vec(input vec_t v, input int idx);
        int g;
        int n;
        g = v.g;
        got[2*g].delete();
        got[2*g+1].delete();
        d_irr[g] = 1'b1;  d_drr[g] = 1'b1;
        d_ival[g] = v.ival; d_iaddr[g] = v.iaddr;
        d_dval[g] = v.dval; d_dtyp[g] = v.dtyp; d_daddr[g] = v.daddr;
        d_wdata[g] = v.wdata; d_wstrb[g] = v.wstrb;
        n = 0;
        while ((d_ival[g] || d_dval[g]) && n < 20) begin
            tick();
            if (acc_i[g]) d_ival[g] = 1'b0;
            if (acc_d[g]) d_dval[g] = 1'b0;
            n++;
        end
        chk($sformatf("vec%0d_accept", idx), 64'(d_ival[g] || d_dval[g]), 64'(0));
        d_ival[g] = 1'b0;
        d_dval[g] = 1'b0;
        n = 0;
        while ((q[2*g].size() > 0 || q[2*g+1].size() > 0) && n < 20) begin
            tick();
            n++;
        end
        if (v.ival)
            chk($sformatf("vec%0d_imem", idx),
                (got[2*g].size() > 0) ? 64'(got[2*g][0]) : 64'hBAD0_BAD0, 64'({1'b0, v.exp_i}));
        if (v.dval)
            chk($sformatf("vec%0d_dmem", idx),
                (got[2*g+1].size() > 0) ? 64'(got[2*g+1][0]) : 64'hBAD0_BAD0, 64'(v.exp_d));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   k;
        int   nv;
        int   ti [NI];
        int   td [NI];
        vec_t v;

        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b0;
            d_rst[g] = 1'b0; d_ival[g] = 1'b0; d_iaddr[g] = '0; d_irr[g] = 1'b1;
            d_dval[g] = 1'b0; d_dtyp[g] = 1'b0; d_daddr[g] = '0; d_wdata[g] = '0;
            d_wstrb[g] = '0; d_drr[g] = 1'b1;
            age[g] = 0;
            for (int w = 0; w < NW; w++) mk[g][w] = 1'b0;
        end
        for (int k2 = 0; k2 < 2*NI; k2++) st[k2] = 0;

        // Directed vectors: {inst, ival, iaddr, dval, dtyp, daddr, wdata, wstrb, exp_i, exp_d}
        addv(0, 0, 0,            1, 1, 32'h10,  32'hDEADBEEF, 4'hF, 0, {1'b1, 32'h0});
        addv(0, 0, 0,            1, 0, 32'h10,  0,            4'h0, 0, {1'b0, 32'hDEADBEEF});
        addv(0, 1, 32'h10,       0, 0, 0,       0,            4'h0, 32'hDEADBEEF, 0);
        addv(0, 0, 0,            1, 1, 32'h0C,  32'h11223344, 4'hF, 0, {1'b1, 32'h0});
        addv(0, 0, 0,            1, 1, 32'h10C, 32'hAABBCCDD, 4'h5, 0, {1'b1, 32'h0});
        addv(0, 0, 0,            1, 0, 32'h0C,  0,            4'h0, 0, {1'b0, 32'h11BB33DD});
        addv(0, 0, 0,            1, 1, 32'h14,  32'h0,        4'hF, 0, {1'b1, 32'h0});
        addv(0, 1, 32'h14,       1, 1, 32'h14,  32'h55,       4'hF, 32'h0, {1'b1, 32'h0});
        addv(0, 1, 32'h14,       0, 0, 0,       0,            4'h0, 32'h55, 0);
        addv(0, 0, 0,            1, 0, 32'h14,  0,            4'h0, 0, {1'b0, 32'h55});
        addv(0, 0, 0,            1, 1, 32'h20,  32'h12345678, 4'hF, 0, {1'b1, 32'h0});
        addv(0, 0, 0,            1, 1, 32'h20,  32'hFFFFFFFF, 4'h0, 0, {1'b1, 32'h0});
        addv(0, 0, 0,            1, 0, 32'h20,  0,            4'h0, 0, {1'b0, 32'h12345678});
        addv(0, 0, 0,            1, 0, 32'h413, 0,            4'h0, 0, {1'b0, 32'hDEADBEEF});
        addv(0, 1, 32'hFFFFFF0C, 0, 0, 0,       0,            4'h0, 32'h11BB33DD, 0);
        addv(2, 0, 0,            1, 1, 32'h00,  32'hA0,       4'hF, 0, {1'b1, 32'h0});
        addv(2, 0, 0,            1, 1, 32'h04,  32'hA1,       4'hF, 0, {1'b1, 32'h0});
        addv(2, 0, 0,            1, 1, 32'h08,  32'hA2,       4'hF, 0, {1'b1, 32'h0});
        addv(2, 0, 0,            1, 1, 32'h0C,  32'hA3,       4'hF, 0, {1'b1, 32'h0});

        // Reset held, then released.
        repeat (3) tick();
        for (int g = 0; g < NI; g++) d_rst[g] = 1'b1;
        tick();

        foreach (vt[i]) run_vec(vt[i], i);

        // Read accepted the cycle after a write to the same word.
        got[1].delete();
        d_dval[0] = 1'b1; d_dtyp[0] = 1'b1; d_daddr[0] = 32'h30;
        d_wdata[0] = 32'hCAFE0001; d_wstrb[0] = 4'hF;
        tick();
        chk("raw_wr_acc", 64'(acc_d[0]), 64'(1));
        d_dtyp[0] = 1'b0;
        tick();
        chk("raw_rd_acc", 64'(acc_d[0]), 64'(1));
        d_dval[0] = 1'b0;
        repeat (4) tick();
        chk("raw_rd_data", (got[1].size() == 2) ? 64'(got[1][1]) : 64'hBAD0_BAD0,
            64'({1'b0, 32'hCAFE0001}));

        // Backpressure on LAT = 3: stall five cycles once the first read is due.
        got[5].delete();
        d_drr[2] = 1'b1; d_dval[2] = 1'b1; d_dtyp[2] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            d_daddr[2] = 32'(4 * r);
            tick();
            chk($sformatf("bp_acc%0d", r), 64'(acc_d[2]), 64'(1));
        end
        d_daddr[2] = 32'h0C;
        d_drr[2] = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("bp_stall_val%0d", s),  64'(dmemresp_val[2]),   64'(1));
            chk($sformatf("bp_stall_data%0d", s), 64'(dmemresp_rdata[2]), 64'(32'hA0));
            chk($sformatf("bp_stall_rdy%0d", s),  64'(dmemreq_rdy[2]),    64'(0));
        end
        d_drr[2] = 1'b1;
        n = 0;
        while (d_dval[2] && n < 10) begin
            tick();
            if (acc_d[2]) d_dval[2] = 1'b0;
            n++;
        end
        chk("bp_acc3", 64'(d_dval[2]), 64'(0));
        d_dval[2] = 1'b0;
        repeat (8) tick();
        chk("bp_count", 64'(got[5].size()), 64'(4));
        for (int r = 0; r < 4; r++)
            chk($sformatf("bp_order%0d", r),
                (got[5].size() > r) ? 64'(got[5][r]) : 64'hBAD0_BAD0, 64'(32'hA0 + r));

        // Reset with a write and a read in flight on LAT = 2.
        d_dval[1] = 1'b1; d_dtyp[1] = 1'b1; d_daddr[1] = 32'h08;
        d_wdata[1] = 32'h77; d_wstrb[1] = 4'hF;
        tick();
        chk("mid_wr_acc", 64'(acc_d[1]), 64'(1));
        d_dtyp[1] = 1'b0; d_daddr[1] = 32'h04;
        tick();
        chk("mid_rd_acc", 64'(acc_d[1]), 64'(1));
        d_dval[1] = 1'b0;
        d_rst[1] = 1'b0;
        repeat (2) tick();
        d_rst[1] = 1'b1;
        nv = 0;
        for (int s = 0; s < 5; s++) begin
            tick();
            nv += int'(dmemresp_val[1]);
        end
        chk("mid_no_resp", 64'(nv), 64'(0));
        v = '{g: 1, ival: 1'b0, iaddr: 32'h0, dval: 1'b1, dtyp: 1'b0, daddr: 32'h08,
              wdata: 32'h0, wstrb: 4'h0, exp_i: 32'h0, exp_d: {1'b0, 32'h77}};
        run_vec(v, 100);

        // Random traffic with random backpressure on every instance.
        for (int t = 0; t < 1500; t++) begin
            for (int g = 0; g < NI; g++) begin
                d_ival[g]  = 1'($urandom_range(0, 1));
                d_iaddr[g] = $urandom() & 32'hFFFF_FF1F;
                d_irr[g]   = ($urandom_range(0, 3) != 0);
                d_dval[g]  = 1'($urandom_range(0, 1));
                d_dtyp[g]  = 1'($urandom_range(0, 1));
                d_daddr[g] = $urandom() & 32'hFFFF_FF1F;
                d_wdata[g] = $urandom();
                d_wstrb[g] = 4'($urandom());
                d_drr[g]   = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        // Full throughput: one request per port per cycle.
        for (int g = 0; g < NI; g++) begin
            ti[g] = 0; td[g] = 0;
            d_ival[g] = 1'b1; d_dval[g] = 1'b1; d_irr[g] = 1'b1; d_drr[g] = 1'b1;
        end
        for (int t = 0; t < 300; t++) begin
            for (int g = 0; g < NI; g++) begin
                d_iaddr[g] = $urandom();
                d_daddr[g] = $urandom() & 32'hFFFF_FF3F;
                d_dtyp[g]  = 1'($urandom_range(0, 1));
                d_wdata[g] = $urandom();
                d_wstrb[g] = 4'($urandom());
            end
            tick();
            for (int g = 0; g < NI; g++) begin
                ti[g] += int'(acc_i[g]);
                td[g] += int'(acc_d[g]);
            end
        end
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("thru_imem%0d", g), 64'(ti[g]), 64'(300));
            chk($sformatf("thru_dmem%0d", g), 64'(td[g]), 64'(300));
            d_ival[g] = 1'b0;
            d_dval[g] = 1'b0;
        end

        repeat (10) tick();
        for (k = 0; k < 2*NI; k++)
            chk($sformatf("drain%0d", k), 64'(q[k].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_mem_pipe.md
Name: proc_mem_pipe

Overview:
- Parametrised successor to the processor's unified instruction/data memory.
- One word array, shared by two ports:
  - imem: read-only.
  - dmem: read/write, with byte strobes.
- Each port uses a val/rdy request and response handshake, with a fixed LAT-cycle pipelined response and backpressure.
- Sits between the pipelined TinyRV1 processor and its memory model. Lets the processor be exercised against non-zero memory latency.

Parameters:
- NWORDS, 64: number of 32-bit words; power of 2, ≥ 4.
- LAT, 1: request-accept to response-valid latency in cycles; range 1..4.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- imemreq_val, input, 1: imem request valid.
- imemreq_rdy, output, 1: imem request ready.
- imemreq_addr, input, 32: imem byte address.
- imemresp_val, output, 1: imem response valid.
- imemresp_rdy, input, 1: imem response ready.
- imemresp_data, output, 32: instruction word.
- dmemreq_val, input, 1: dmem request valid.
- dmemreq_rdy, output, 1: dmem request ready.
- dmemreq_type, input, 1: 0 = read, 1 = write.
- dmemreq_addr, input, 32: dmem byte address.
- dmemreq_wdata, input, 32: write data.
- dmemreq_wstrb, input, 4: byte enables; bit i selects wdata[8i+7:8i].
- dmemresp_val, output, 1: dmem response valid.
- dmemresp_rdy, input, 1: dmem response ready.
- dmemresp_type, output, 1: echo of the request type.
- dmemresp_rdata, output, 32: read data; 0 for write responses.

Behaviour:
- Indexing: word index = addr[$clog2(NWORDS)+1:2].
  - addr[1:0] ignored (no misalignment fault).
  - Upper bits ignored: out-of-range addresses wrap modulo NWORDS.
- Array:
  - Not reset; contents X until written or preloaded by the testbench.
  - Reset affects only control/valid state.
- Per-port pipeline: LAT stages, each holding {valid, data, type}.
  - Stage valid bits clear asynchronously when rst = 0.
  - While in reset: all *_rdy = 0, all *resp_val = 0, resp data = 0.
- Advance condition per port: adv = !(stage[LAT-1].valid && !resp_rdy).
  - Whole-port stall: bubbles do not compress.
  - Ports are fully independent; no arbitration.
- Request ready:
  - req_rdy = adv.
  - Request accepted on a cycle with req_val && req_rdy.
- Read, dmem type 0 or any imem request:
  - Array read combinationally in the accept cycle; data enters stage 0.
  - Response valid exactly LAT cycles after accept when no stall occurs.
  - Each stall cycle adds one cycle.
- Write, dmem type 1:
  - Bytes with wstrb = 1 are written at the accept-cycle clock edge; others are preserved.
  - A write response (type 1, rdata 0) still flows through the pipeline with the same latency.
  - wstrb = 0 produces a normal response and no array change.
- Ordering:
  - Responses are in request order per port.
  - A dmem read accepted the cycle after a write to the same word returns the new data.
- Same-cycle collision: dmem write and imem read to the same word in one cycle.
  - imem returns the old word (read-before-write).
  - The new value is visible from the next cycle.
- Response stability: resp_val and resp data/type are held stable while resp_val && !resp_rdy.
- Throughput: one request per port per cycle when resp_rdy is held at 1.
- Reset mid-operation:
  - All in-flight responses are discarded.
  - Writes already committed remain in the array.
  - After rst returns to 1, req_rdy = 1 on the first edge.

Test Plan:
- Reset and ready:
  - Hold rst = 0 → all *_rdy and *resp_val = 0.
  - Release → imemreq_rdy = dmemreq_rdy = 1.
- Basic write/read, LAT = 1:
  - dmem write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF → resp (type 1, rdata 0) one cycle later.
  - dmem read 0x10 → rdata 0xDEADBEEF one cycle after accept.
  - imem read 0x10 → 0xDEADBEEF.
- Byte strobes and wrap:
  - Word 3 = 0x11223344; write addr 0x10C (wraps to word 3 when NWORDS = 64), wdata 0xAABBCCDD, wstrb 0b0101 → read 0x0C returns 0x11BB33DD.
- Collision:
  - Word 5 = 0x0; same cycle: dmem write 0x14 = 0x55, imem read 0x14 → imem data 0x0.
  - Next imem read 0x14 → 0x55.
- Backpressure, LAT = 3:
  - Stream 4 dmem reads of words 0..3 holding 0xA0..0xA3; dmemresp_rdy = 0 for 5 cycles after the first response appears.
  - Expect: dmemreq_rdy = 0 during the stall, resp held at 0xA0, then 0xA0..0xA3 in order with no loss or duplication.
- Reset mid-flight, LAT = 2:
  - Accept a write 0x08 = 0x77 and a read of 0x04, then assert rst the next cycle → no responses after release.
  - A subsequent read of 0x08 returns 0x77.
